// File: rtl/tenzo_pkg.sv
// -----------------------------------------------------------------------------
// tenzo_pkg
// Shared definitions for the strain-gauge limit monitor:
//   - limit_state_e     : per-channel debounce FSM states
//   - TENZO_DEFAULT_THR : reset value of every channel threshold
//   - TENZO_DEFAULT_HYS : reset value of every channel hysteresis
//   - tenzo_idx_w()     : width of a channel index (never less than 1 bit)
// -----------------------------------------------------------------------------
package tenzo_pkg;

    typedef enum logic [1:0] {
        ST_BELOW = 2'd0,  // limit clear, no set run in progress
        ST_RISE  = 2'd1,  // limit clear, counting qualifying set samples
        ST_ABOVE = 2'd2,  // limit set, no release run in progress
        ST_FALL  = 2'd3   // limit set, counting qualifying release samples
    } limit_state_e;

    localparam int TENZO_DEFAULT_THR = 50;
    localparam int TENZO_DEFAULT_HYS = 5;

    // A single-channel build still needs a 1-bit index port.
    function automatic int tenzo_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tenzo_channel.sv
// -----------------------------------------------------------------------------
// tenzo_channel
// One strain-gauge channel: threshold/hysteresis registers, debounced limit
// FSM and peak-hold register.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   smp_valid  in   sample for this channel (already decoded, index in range)
//   smp_data   in   DATA_W  unsigned sample
//   cfg_we     in   config write for this channel (already decoded)
//   cfg_thr    in   DATA_W  new threshold
//   cfg_hys    in   DATA_W  new hysteresis
//   peak_clr   in   clear the peak-hold register
//   limit      out  registered debounced limit flag (ABOVE or FALL)
//   peak       out  DATA_W  maximum sample since the last clear
// -----------------------------------------------------------------------------
module tenzo_channel
    import tenzo_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEBOUNCE    = 4,
    parameter int DEFAULT_THR = TENZO_DEFAULT_THR,
    parameter int DEFAULT_HYS = TENZO_DEFAULT_HYS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    input  logic              cfg_we,
    input  logic [DATA_W-1:0] cfg_thr,
    input  logic [DATA_W-1:0] cfg_hys,
    input  logic              peak_clr,
    output logic              limit,
    output logic [DATA_W-1:0] peak
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    // Counter value held on the sample before the one that completes a run.
    localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(DEBOUNCE - 1);

    limit_state_e      state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [DATA_W-1:0] thr, hys;
    logic [DATA_W-1:0] rel;
    logic              set_hit, rel_hit;

    // Next-state logic. Comparisons use the registered thr/hys, so a sample
    // that coincides with a config write sees the old values.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state;
        cnt_d   = cnt;
        rel     = (hys >= thr) ? '0 : thr - hys;  // saturate at 0: never releases
        set_hit = (smp_data >= thr);
        rel_hit = (smp_data < rel);

        if (smp_valid) begin
            unique case (state)
                ST_BELOW: begin
                    if (set_hit) begin
                        if (DEBOUNCE == 1) begin
                            state_d = ST_ABOVE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_RISE;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_RISE: begin
                    if (!set_hit) begin
                        state_d = ST_BELOW;
                        cnt_d   = '0;
                    end else if (cnt == CNT_FINAL) begin
                        state_d = ST_ABOVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                ST_ABOVE: begin
                    if (rel_hit) begin
                        if (DEBOUNCE == 1) begin
                            state_d = ST_BELOW;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_FALL;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_FALL: begin
                    if (!rel_hit) begin
                        state_d = ST_ABOVE;
                        cnt_d   = '0;
                    end else if (cnt == CNT_FINAL) begin
                        state_d = ST_BELOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_BELOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: thr/hys are per-channel configuration registers and must come out
    // of reset at their defaults, so they sit in the reset branch like any
    // other state rather than being left unreset as a storage array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BELOW;
            cnt   <= '0;
            limit <= 1'b0;
            thr   <= DATA_W'(DEFAULT_THR);
            hys   <= DATA_W'(DEFAULT_HYS);
            peak  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout so every register
            // samples pre-edge values regardless of statement order.
            state <= state_d;
            cnt   <= cnt_d;
            limit <= (state_d == ST_ABOVE) || (state_d == ST_FALL);

            if (cfg_we) begin
                thr <= cfg_thr;
                hys <= cfg_hys;
            end

            // A clear coinciding with a sample restarts the hold at that sample.
            if (peak_clr) begin
                peak <= smp_valid ? smp_data : '0;
            end else if (smp_valid && (smp_data > peak)) begin
                peak <= smp_data;
            end
        end
    end

endmodule

// File: rtl/tenzo_limit_monitor.sv
// -----------------------------------------------------------------------------
// tenzo_limit_monitor
// Multi-channel strain-gauge limit monitor. Decodes the shared sample and
// config buses to NUM_CH tenzo_channel instances and aggregates their flags.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   s_valid      in   sample strobe
//   s_ch         in   IDX_W   sample channel index
//   s_data       in   DATA_W  unsigned sample
//   cfg_we       in   config write strobe
//   cfg_ch       in   IDX_W   config channel index
//   cfg_thr      in   DATA_W  new threshold
//   cfg_hys      in   DATA_W  new hysteresis
//   peak_clr     in   NUM_CH  per-channel peak clear
//   o_limit      out  NUM_CH  debounced limit flags (latency 1)
//   o_limit_any  out  OR of o_limit (latency 2)
//   o_irq        out  one-cycle pulse when any o_limit bit rises (latency 2)
//   o_peak       out  NUM_CH*DATA_W  peak-hold values, channel k at [k*DATA_W +: DATA_W]
//   o_err        out  one-cycle pulse for an out-of-range s_ch or cfg_ch
// -----------------------------------------------------------------------------
module tenzo_limit_monitor
    import tenzo_pkg::*;
#(
    parameter int NUM_CH      = 5,
    parameter int DATA_W      = 8,
    parameter int DEBOUNCE    = 4,
    parameter int DEFAULT_THR = TENZO_DEFAULT_THR,
    parameter int DEFAULT_HYS = TENZO_DEFAULT_HYS,
    localparam int IDX_W      = tenzo_idx_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic [IDX_W-1:0]         s_ch,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     cfg_we,
    input  logic [IDX_W-1:0]         cfg_ch,
    input  logic [DATA_W-1:0]        cfg_thr,
    input  logic [DATA_W-1:0]        cfg_hys,
    input  logic [NUM_CH-1:0]        peak_clr,
    output logic [NUM_CH-1:0]        o_limit,
    output logic                     o_limit_any,
    output logic                     o_irq,
    output logic [NUM_CH*DATA_W-1:0] o_peak,
    output logic                     o_err
);

    // One extra bit so NUM_CH itself is representable for the range check.
    localparam logic [IDX_W:0] NUM_CH_L = (IDX_W + 1)'(NUM_CH);

    logic              s_ok, cfg_ok;
    logic [NUM_CH-1:0] limit_w;
    logic [NUM_CH-1:0] limit_prev;

    assign s_ok   = ({1'b0, s_ch}   < NUM_CH_L);
    assign cfg_ok = ({1'b0, cfg_ch} < NUM_CH_L);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic smp_hit, cfg_hit;

        // Out-of-range indices never reach a channel, so they change no state.
        assign smp_hit = s_valid && s_ok   && (s_ch   == IDX_W'(k));
        assign cfg_hit = cfg_we  && cfg_ok && (cfg_ch == IDX_W'(k));

        tenzo_channel #(
            .DATA_W      (DATA_W),
            .DEBOUNCE    (DEBOUNCE),
            .DEFAULT_THR (DEFAULT_THR),
            .DEFAULT_HYS (DEFAULT_HYS)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .smp_valid (smp_hit),
            .smp_data  (s_data),
            .cfg_we    (cfg_hit),
            .cfg_thr   (cfg_thr),
            .cfg_hys   (cfg_hys),
            .peak_clr  (peak_clr[k]),
            .limit     (limit_w[k]),
            .peak      (o_peak[k*DATA_W +: DATA_W])
        );
    end

    // Channel flags are already registered inside each channel.
    assign o_limit = limit_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit_prev  <= '0;
            o_limit_any <= 1'b0;
            o_irq       <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            limit_prev  <= o_limit;
            o_limit_any <= |o_limit;
            o_irq       <= |(o_limit & ~limit_prev);
            o_err       <= (s_valid && !s_ok) || (cfg_we && !cfg_ok);
        end
    end

endmodule

// File: tb/tb_tenzo_limit_monitor.sv
// -----------------------------------------------------------------------------
// tb_tenzo_limit_monitor
// Directed self-checking bench for tenzo_limit_monitor with default parameters
// (NUM_CH=5, DATA_W=8, DEBOUNCE=4, thr=50, hys=5 -> release below 45).
// Inputs change on the falling edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_tenzo_limit_monitor;

    localparam int NUM_CH = 5;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 3;

    logic                     clk;
    logic                     rst;
    logic                     s_valid;
    logic [IDX_W-1:0]         s_ch;
    logic [DATA_W-1:0]        s_data;
    logic                     cfg_we;
    logic [IDX_W-1:0]         cfg_ch;
    logic [DATA_W-1:0]        cfg_thr;
    logic [DATA_W-1:0]        cfg_hys;
    logic [NUM_CH-1:0]        peak_clr;
    logic [NUM_CH-1:0]        o_limit;
    logic                     o_limit_any;
    logic                     o_irq;
    logic [NUM_CH*DATA_W-1:0] o_peak;
    logic                     o_err;

    int errors = 0;
    int checks = 0;

    tenzo_limit_monitor #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DATA_W),
        .DEBOUNCE (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ch        (s_ch),
        .s_data      (s_data),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_thr     (cfg_thr),
        .cfg_hys     (cfg_hys),
        .peak_clr    (peak_clr),
        .o_limit     (o_limit),
        .o_limit_any (o_limit_any),
        .o_irq       (o_irq),
        .o_peak      (o_peak),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one sample for one clock; returns on the following falling edge.
    task automatic smp(input int ch, input int data);
        s_valid = 1'b1;
        s_ch    = IDX_W'(ch);
        s_data  = DATA_W'(data);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic smp_n(input int ch, input int data, input int n);
        for (int i = 0; i < n; i++) smp(ch, data);
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_ch     = '0;
        s_data   = '0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_thr  = '0;
        cfg_hys  = '0;
        peak_clr = '0;

        // ---- reset state ----
        @(negedge clk);
        @(negedge clk);
        check("rst_limit", 64'(o_limit), 64'h0);
        check("rst_any",   64'(o_limit_any), 64'h0);
        check("rst_irq",   64'(o_irq), 64'h0);
        check("rst_peak",  64'(o_peak), 64'h0);
        check("rst_err",   64'(o_err), 64'h0);
        rst = 1'b0;
        idle();

        // ---- four samples of 50 on ch0 assert, irq one cycle later ----
        smp_n(0, 50, 3);
        check("c0_after3", 64'(o_limit), 64'h00);
        smp(0, 50);
        check("c0_after4", 64'(o_limit), 64'h01);
        check("c0_irq_lat", 64'(o_irq), 64'h0);
        idle();
        check("c0_irq", 64'(o_irq), 64'h1);
        check("c0_any", 64'(o_limit_any), 64'h1);
        idle();
        check("c0_irq_off", 64'(o_irq), 64'h0);
        check("c0_peak", 64'(o_peak[7:0]), 64'h32);

        // ---- hysteresis: 46 holds, 44 run broken by 46, then full 44 run ----
        smp_n(0, 46, 4);
        check("c0_hold46", 64'(o_limit), 64'h01);
        smp_n(0, 44, 2);
        smp(0, 46);
        smp_n(0, 44, 3);
        check("c0_fall_restart", 64'(o_limit), 64'h01);
        smp(0, 44);
        check("c0_release", 64'(o_limit), 64'h00);

        // ---- interrupted set run on ch2: 50,50,49,50 then three more 50 ----
        smp(2, 50); smp(2, 50); smp(2, 49); smp(2, 50);
        check("c2_broken", 64'(o_limit), 64'h00);
        smp_n(2, 50, 2);
        check("c2_after6", 64'(o_limit), 64'h00);
        smp(2, 50);
        check("c2_after7", 64'(o_limit), 64'h04);

        // ---- ch1 thr=10 hys=20; coincident sample uses old thr=50 ----
        cfg_we  = 1'b1;
        cfg_ch  = 3'd1;
        cfg_thr = 8'd10;
        cfg_hys = 8'd20;
        smp(1, 10);
        cfg_we  = 1'b0;
        smp_n(1, 10, 3);
        check("c1_old_cfg", 64'(o_limit), 64'h04);
        smp(1, 10);
        check("c1_set", 64'(o_limit), 64'h06);
        smp_n(1, 0, 6);
        check("c1_no_release", 64'(o_limit), 64'h06);

        // ---- out-of-range sample and config ----
        smp(7, 99);
        check("err_s", 64'(o_err), 64'h1);
        check("err_s_peak", 64'(o_peak), 64'h00_00_32_0a_32);
        check("err_s_limit", 64'(o_limit), 64'h06);
        cfg_we  = 1'b1;
        cfg_ch  = 3'd5;
        cfg_thr = 8'd0;
        cfg_hys = 8'd0;
        idle();
        cfg_we  = 1'b0;
        check("err_cfg", 64'(o_err), 64'h1);
        idle();
        check("err_off", 64'(o_err), 64'h0);
        // A config write to ch5 (nonexistent) must not retune ch0: 49 stays below.
        smp_n(0, 49, 4);
        check("err_cfg_nochg", 64'(o_limit), 64'h06);

        // ---- peak hold on ch3 ----
        smp(3, 20);
        smp(3, 10);
        check("c3_peak_max", 64'(o_peak[31:24]), 64'h14);
        peak_clr = 5'b01000;
        smp(3, 33);
        peak_clr = '0;
        check("c3_clr_smp", 64'(o_peak[31:24]), 64'h21);
        peak_clr = 5'b01000;
        idle();
        peak_clr = '0;
        check("c3_clr", 64'(o_peak[31:24]), 64'h00);
        check("c0_peak_kept", 64'(o_peak[7:0]), 64'h32);

        // ---- reset mid-debounce on ch4 ----
        smp_n(4, 60, 3);
        rst = 1'b1;
        #1;
        check("mid_rst_limit", 64'(o_limit), 64'h0);
        check("mid_rst_peak",  64'(o_peak), 64'h0);
        check("mid_rst_any",   64'(o_limit_any), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        smp_n(4, 60, 3);
        check("c4_after3", 64'(o_limit), 64'h00);
        smp(4, 60);
        check("c4_after4", 64'(o_limit), 64'h10);
        idle();
        check("c4_irq", 64'(o_irq), 64'h1);
        check("c4_peak", 64'(o_peak), 64'h3c_00_00_00_00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
